multicycle_control_fsm: RTL
===========================

# multicycle_control_fsm

Multicycle sequencer for the ARM-subset datapath: decodes the instruction held in the instruction register, steps a state machine through fetch/decode/execute/memory/writeback, and drives every datapath enable and mux select per cycle. It owns the NZCV flag registers and the condition check, and stalls on a memory-ready handshake. It sits between the instruction register/ALU and the shared instruction/data memory, and is the multicycle counterpart of the single-cycle control unit.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- Cond  in  4  instruction bits [31:28], from the instruction register
- Op  in  2  instruction bits [27:26]
- Funct  in  6  instruction bits [25:20]; [5]=I, [4:1]=cmd, [0]=S (data-processing) or L (memory)
- Rd  in  4  instruction bits [15:12]
- Flags  in  4  live ALU flags {N,Z,C,V}
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  load the PC
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut-path result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load the instruction register
- ResultSrc  out  2  00=ALUOut, 01=data read, 10=ALU result
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=register B, 01=extended immediate, 10=constant 4
- ImmSrc  out  2  equals Op
- RegWrite  out  1  register file write
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
- State  out  4  current state encoding (debug/verification)

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Encodings 10–15 return to FETCH on the next edge.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00. IRWrite and PCWrite=1 only when MemReady=1; then go to DECODE, otherwise hold.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state by opcode:
  - Op=01 → MEMADR
  - Op=00 with I=0 → EXECR; with I=1 → EXECI
  - Op=10 → BRANCH
  - Op=11 → FETCH (undefined instruction, no side effects)
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Go to MEMREAD if L=1, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. PCWrite=CondEx when Rd=15. Then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=CondEx. Hold until MemReady, then FETCH.
- EXECR/EXECI: ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI). ALUControl is decoded from cmd. Flag registers load here, then ALUWB.
- Command decode:
  - 0100 ADD → 00; 0010 SUB → 01; 0000 AND → 10; 1100 ORR → 11
  - 1010 CMP → 01 with NoWrite=1
  - any other cmd → 00 with NoWrite=1 and no flag write
- ALUWB: ResultSrc=00, RegWrite=CondEx&~NoWrite. PCWrite=CondEx&~NoWrite when Rd=15. Then FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ADD, PCWrite=CondEx. Then FETCH.
- Flag write control:
  - FlagW[1] (N,Z) = S | CMP
  - FlagW[0] (C,V) = (S | CMP) & arithmetic (ADD/SUB/CMP)
  - Enables are FlagW[i] & CondEx, active only in EXECR/EXECI.
- CondEx is evaluated against the stored flags:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V)
  - AL 1; 1111 → 0
- Any output not listed for a state is 0. MemWrite, RegWrite, PCWrite and IRWrite are never asserted outside the states named above.

## Timing
- Reset (rst=0, asynchronous): State=FETCH, stored flags=0000.
- Outputs during reset: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00. PCWrite, IRWrite, MemWrite and RegWrite are 0. ImmSrc and RegSrc follow their combinational decode.
- Reset mid-instruction abandons it. No write strobe fires in the reset cycle.
- Outputs are combinational from State and the instruction fields (Moore-style, plus MemReady gating in FETCH).
- Latency with MemReady tied to 1:
  - data-processing 4 cycles
  - branch 3 cycles
  - store 4 cycles
  - load 5 cycles
  - undefined 2 cycles
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. MemWrite stays asserted throughout a MEMWRITE stall.
- A flag update is visible to CondEx on the cycle after EXECR/EXECI, so the next instruction sees it.

## Test plan
- Reset with MemReady=0 → State=0, all strobes 0. Release with MemReady=1 → IRWrite=PCWrite=1 in the first cycle, State=1 next.
- ADDS register (Cond=1110, Op=00, Funct=001001), ALU Flags=0100 → states 0,1,6,8. Stored Z=1. RegWrite=1 in ALUWB.
- Next instruction BEQ (Cond=0000, Op=10) → states 0,1,9 with PCWrite=1. Same instruction after a flags=0000 update → PCWrite=0.
- LDR (Op=01, Funct[0]=1, Rd=3) with MemReady low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4. RegWrite=1 only in MEMWB. ResultSrc=01.
- CMP (cmd 1010, S=0) → flags load with Flags=1001, RegWrite=0 in ALUWB. ORRS → only N,Z update, C,V retained.
- STR with Cond=1111 → MemWrite=0 throughout MEMWRITE. Op=11 → DECODE returns to FETCH with no strobes.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle sequencer for the ARM-subset datapath: state machine, per-state
// datapath controls, NZCV flag registers and condition check.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Flags,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [1:0] RegSrc,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
    MEMWB    = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
    ALUWB    = 4'd8, BRANCH = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q;  // {N,Z,C,V}

  // Data-processing command decode
  logic [1:0] dp_alu;
  logic       nowrite, cmd_ok, is_cmp, is_arith, flagw_nz, flagw_cv;
  always_comb begin
    dp_alu   = 2'b00;
    nowrite  = 1'b0;
    cmd_ok   = 1'b1;
    is_cmp   = 1'b0;
    is_arith = 1'b0;
    case (Funct[4:1])
      4'b0100: is_arith = 1'b1;
      4'b0010: begin dp_alu = 2'b01; is_arith = 1'b1; end
      4'b0000: dp_alu = 2'b10;
      4'b1100: dp_alu = 2'b11;
      4'b1010: begin dp_alu = 2'b01; nowrite = 1'b1; is_cmp = 1'b1; is_arith = 1'b1; end
      default: begin nowrite = 1'b1; cmd_ok = 1'b0; end
    endcase
  end
  assign flagw_nz = cmd_ok & (Funct[0] | is_cmp);
  assign flagw_cv = flagw_nz & is_arith;

  logic fn, fz, fc, fv, cond_ex;
  assign {fn, fz, fc, fv} = flags_q;
  always_comb begin
    case (Cond)
      4'h0: cond_ex = fz;
      4'h1: cond_ex = ~fz;
      4'h2: cond_ex = fc;
      4'h3: cond_ex = ~fc;
      4'h4: cond_ex = fn;
      4'h5: cond_ex = ~fn;
      4'h6: cond_ex = fv;
      4'h7: cond_ex = ~fv;
      4'h8: cond_ex = fc & ~fz;
      4'h9: cond_ex = ~fc | fz;
      4'hA: cond_ex = (fn == fv);
      4'hB: cond_ex = (fn != fv);
      4'hC: cond_ex = ~fz & (fn == fv);
      4'hD: cond_ex = fz | (fn != fv);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = MemReady ? DECODE : FETCH;
      DECODE:   case (Op)
                  2'b01:   state_d = MEMADR;
                  2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                  2'b10:   state_d = BRANCH;
                  default: state_d = FETCH;
                endcase
      MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MemReady ? MEMWB : MEMREAD;
      MEMWRITE: state_d = MemReady ? FETCH : MEMWRITE;
      EXECR,
      EXECI:    state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  logic in_exec;
  assign in_exec = (state_q == EXECR) || (state_q == EXECI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (in_exec && cond_ex && flagw_nz) flags_q[3:2] <= Flags[3:2];
      if (in_exec && cond_ex && flagw_cv) flags_q[1:0] <= Flags[1:0];
    end
  end

  // Reset forces FETCH, so gating the FETCH strobes with rst keeps every
  // write strobe quiet while reset is held.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    RegWrite   = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        IRWrite = MemReady & rst;
        PCWrite = MemReady & rst;
      end
      DECODE: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      MEMADR: ALUSrcB = 2'b01;
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
        PCWrite   = cond_ex & (Rd == 4'hF);
      end
      MEMWRITE: begin AdrSrc = 1'b1; MemWrite = cond_ex; end
      EXECR: ALUControl = dp_alu;
      EXECI: begin ALUControl = dp_alu; ALUSrcB = 2'b01; end
      ALUWB: begin
        RegWrite = cond_ex & ~nowrite;
        PCWrite  = cond_ex & ~nowrite & (Rd == 4'hF);
      end
      BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = cond_ex; end
      default: ;
    endcase
  end

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};
  assign State  = state_q;

endmodule
